// File: rtl/countdown_timer_ctrl.sv
// Two-digit countdown sequencer: drives the load and step controls of a pair of
// external cascaded BCD down counters and reports running / time-up status.
module countdown_timer_ctrl #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       start,
   input  logic       pause,
   input  logic [3:0] init_tens,
   input  logic [3:0] init_units,
   input  logic [3:0] tens_count,
   input  logic [3:0] units_count,
   output logic       cnt_enable,
   output logic       loadN,
   output logic       units_en_cnt,
   output logic       tens_en_cnt,
   output logic       running,
   output logic       time_up
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_RUN, S_PAUSED, S_EXPIRED
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          step;

   assign step = (state_q == S_RUN) && (presc_q == LAST);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= S_IDLE;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
      end
   end

   // Prescaler only advances in RUN, so paused cycles never count toward a step.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      case (state_q)
         S_LOAD: begin
            presc_d = '0;
            state_d = (init_tens == 4'd0 && init_units == 4'd0) ? S_EXPIRED : S_RUN;
         end
         S_RUN: begin
            presc_d = step ? '0 : presc_q + PW'(1);
            if (step && tens_count == 4'd0 && units_count == 4'd1)
               state_d = S_EXPIRED;
            else if (pause)
               state_d = S_PAUSED;
         end
         S_PAUSED: begin
            if (!pause)
               state_d = S_RUN;
         end
         default: ;
      endcase
      if (start)
         state_d = S_LOAD;
   end

   // Borrow into tens happens on the step that wraps units from 0 to 9.
   always_comb begin
      cnt_enable   = 1'b1;
      loadN        = (state_q != S_LOAD);
      units_en_cnt = step;
      tens_en_cnt  = step && (units_count == 4'd0);
      running      = (state_q == S_RUN);
      time_up      = (state_q == S_EXPIRED);
   end

endmodule

// File: doc/countdown_timer_ctrl.md
# countdown_timer_ctrl

- Sequences a pair of cascaded `down_counter` BCD digit instances (tens, units) into a two-digit game countdown timer for the Road Fighter game logic.
- Generates the once-per-step decrement pulses, the load strobe and the borrow into the tens digit.
- Handles start, restart and pause, and raises a `time_up` flag when the display reaches 00.
- Owns no digit storage: it observes the counters' `count` outputs and drives their control inputs.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clock cycles per countdown step (1 s at 50 MHz). Must be ≥ 2.

Ports:
- `clk` in 1: system clock, single clock domain.
- `resetN` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse. Loads the initial value and starts counting. Accepted in any state.
- `pause` in 1: level. While high in RUN, counting freezes.
- `init_tens` in 4: BCD initial tens digit (0–9), sampled by the counters during the load cycle.
- `init_units` in 4: BCD initial units digit (0–9).
- `tens_count` in 4: tens counter `count` output.
- `units_count` in 4: units counter `count` output.
- `cnt_enable` out 1: drives `enable` of both counters. Constant 1 after reset.
- `loadN` out 1: drives `loadN` of both counters. Active-low.
- `units_en_cnt` out 1: drives units `enable_cnt`.
- `tens_en_cnt` out 1: drives tens `enable_cnt`.
- `running` out 1: high in RUN.
- `time_up` out 1: high in EXPIRED.

## Operation
State machine states: IDLE, LOAD, RUN, PAUSED, EXPIRED. Reset enters IDLE.

The prescaler is a register of width `$clog2(TICK_DIV)` and resets to 0.

Reset values of outputs: `loadN`=1, `units_en_cnt`=0, `tens_en_cnt`=0, `running`=0, `time_up`=0, `cnt_enable`=1.

State behaviour:
- **IDLE**: all control outputs inactive. `start` → LOAD.
- **LOAD** (exactly 1 cycle): `loadN`=0. Clears the prescaler. Next state:
  - RUN if the loaded value is nonzero;
  - EXPIRED if `init_tens`==0 and `init_units`==0.
- **RUN**:
  - The prescaler increments each cycle.
  - When the prescaler == `TICK_DIV`-1, a step occurs: the prescaler wraps to 0 and `units_en_cnt`=1 for that cycle.
  - `tens_en_cnt` = step AND (`units_count`==0). This is the borrow; the units counter wraps 0→9 on its own.
  - If a step occurs with `tens_count`==0 and `units_count`==1, the next state is EXPIRED. The counters reach 00 on the same edge.
  - `pause`=1 with no step in the same cycle → PAUSED. The prescaler holds its value.
- **PAUSED**:
  - The prescaler holds and both `en_cnt` outputs are 0.
  - `pause`=0 → RUN, and the prescaler resumes from the held value.
- **EXPIRED**: `time_up`=1 and both `en_cnt` outputs are 0. The counters hold 00.

Priorities:
- `start` beats everything: from any state, `start` → LOAD on the next edge. Any step due in that cycle is still issued.
- A step beats `pause`: a step due in the same cycle that `pause` rises is issued, then the block enters PAUSED.

Other rules:
- Outputs are decoded from the registered state and prescaler. The only input-to-output combinational path is `units_count` → `tens_en_cnt`.
- Counts above 9 are outside the contract. The block never steps below 00.

## Timing
- `start` sampled high at edge N:
  - LOAD runs during cycle N..N+1 with `loadN` low;
  - the counters load at edge N+1;
  - RUN is entered at edge N+1 with the prescaler at 0.
- The first step is asserted during the `TICK_DIV`-th cycle of RUN. Later steps occur every `TICK_DIV` cycles, excluding cycles spent in PAUSED.
- EXPIRED is entered on the same edge at which the counters reach 00.
- `time_up` rises in the cycle after that edge.
- An asynchronous `resetN` assertion mid-RUN forces IDLE and the reset output values immediately, with no pending step.

## Test plan
- **Load and step** (`TICK_DIV`=4, init 12, `start` pulse): `loadN` low for exactly 1 cycle; counts read 12; the first `units_en_cnt` pulse comes 4 cycles after RUN entry; counts read 11.
- **Borrow** (init 10, `TICK_DIV`=4): at the first step, `units_en_cnt` and `tens_en_cnt` are both high in the same cycle; counts read 09. Later steps show `tens_en_cnt`=0.
- **Expiry** (init 02): after 2 steps, counts read 00 and `time_up`=1 with `running`=0; no further `en_cnt` pulses for 20 cycles.
- **Zero init** (init 00, `start`): LOAD, then EXPIRED directly; no `en_cnt` pulse.
- **Pause mid-period** (`TICK_DIV`=4): raise `pause` when the prescaler is 1, hold for 10 cycles, then release. The next step arrives exactly 2 RUN cycles after release.
- **Restart and reset** (`start` during RUN with init 35):
  - the counters reload to 35 and the prescaler is 0;
  - `resetN` low mid-RUN puts all outputs at their reset values asynchronously, and the block stays in IDLE until `start`.
